// File: rtl/reg_dump_reader_pkg.sv
// Shared constants and FSM encoding for the register-file dump reader.
// The register file uses the same width constants.
package reg_dump_reader_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StSend = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks a wrapping, inclusive range of the register file through one read port
// and streams each captured word out over a valid/ready interface.
module reg_dump_reader
  import reg_dump_reader_pkg::state_e;
  import reg_dump_reader_pkg::StIdle;
  import reg_dump_reader_pkg::StRead;
  import reg_dump_reader_pkg::StSend;
  import reg_dump_reader_pkg::StDone;
#(
  parameter int unsigned ADDR_W = reg_dump_reader_pkg::ADDR_W,
  parameter int unsigned DATA_W = reg_dump_reader_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  // Next-state: FSM plus the wrapping address counter.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    end_d      = end_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cur_d   = first_addr;
          end_d   = last_addr;
          state_d = StRead;
        end
      end
      StRead: begin
        // Snapshot: a write landing on this same edge is not observed.
        out_data_d = rf_data;
        out_addr_d = cur_q;
        state_d    = StSend;
      end
      StSend: begin
        if (out_ready) begin
          if (cur_q == end_q) begin
            state_d = StDone;
          end else begin
            cur_d   = cur_q + AddrOne;
            state_d = StRead;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cur_q      <= '0;
      end_q      <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      end_q      <= end_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
    end
  end

  // Output decode.
  always_comb begin
    rf_addr   = '0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      StIdle: busy = 1'b0;
      StRead: rf_addr = cur_q;
      StSend: out_valid = 1'b1;
      StDone: done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign out_addr = out_addr_q;
  assign out_data = out_data_q;

  // Word on the output must not change while the consumer stalls.
  property p_hold_while_stalled;
    @(posedge clk) disable iff (!rst)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_addr) && $stable(out_data));
  endproperty
  a_hold_while_stalled: assert property (p_hold_while_stalled);

  property p_done_single;
    @(posedge clk) disable iff (!rst) done |=> !done && !busy;
  endproperty
  a_done_single: assert property (p_done_single);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboarded bench for reg_dump_reader: stimulus pushes expected words, a
// monitor pops and compares them whenever the DUT presents a word.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  first_addr = '0;
  logic [4:0]  last_addr = '0;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  logic [31:0] mem [32];

  reg_dump_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .first_addr(first_addr),
    .last_addr (last_addr),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  assign rf_data = mem[rf_addr];

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } word_t;

  word_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    done_cnt = 0;
  int    ready_mode = 0;  // 0: always ready, 1: random, 2: held low

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compare the head of the scoreboard every cycle a word is shown.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h required=none", out_addr);
        end else begin
          check("out_addr", 64'(out_addr), 64'(exp_q[0].a));
          check("out_data", 64'(out_data), 64'(exp_q[0].d));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        check("done_with_words_left", 64'(exp_q.size()), 64'd0);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  function automatic int word_count(input int f, input int l);
    return ((l - f + 32) % 32) + 1;
  endfunction

  task automatic start_dump(input int f, input int l);
    int n;
    n = word_count(f, l);
    for (int k = 0; k < n; k++) begin
      int a;
      a = (f + k) % 32;
      exp_q.push_back({5'(a), mem[a]});
    end
    first_addr = 5'(f);
    last_addr  = 5'(l);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    first_addr = 5'($urandom);
    last_addr  = 5'($urandom);
    check("busy_after_start", 64'(busy), 64'd1);
    check("rf_addr_in_read", 64'(rf_addr), 64'(f));
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    forever begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (done) break;
      if (cycles > 2000) begin
        checks++;
        failures++;
        $display("FAIL done_timeout actual=%0d required=done", cycles);
        break;
      end
    end
    @(posedge clk);
    #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("busy_after_done", 64'(busy), 64'd0);
  endtask

  task automatic run_dump(input int f, input int l, input bit timed);
    int cycles;
    int d0;
    d0 = done_cnt;
    start_dump(f, l);
    wait_done(cycles);
    if (timed) check("dump_cycles", 64'(cycles), 64'(2 * word_count(f, l)));
    check("done_pulses", 64'(done_cnt - d0), 64'd1);
    check("all_words_seen", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int cyc;
    int d0;
    bit hit;

    for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 + 32'(i);
    repeat (2) @(posedge clk);
    #1;
    check("reset_rf_addr", 64'(rf_addr), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_addr", 64'(out_addr), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Full 32-word dump, ready held high.
    run_dump(0, 31, 1'b1);

    // Wrapping range 30, 31, 0, 1.
    run_dump(30, 1, 1'b1);

    // Single word with consumer stalled for 10 cycles.
    ready_mode = 2;
    @(posedge clk);
    #1;
    d0 = done_cnt;
    start_dump(5, 5);
    hit = 1'b0;
    for (int t = 0; t < 50 && !hit; t++) begin
      @(negedge clk);
      hit = out_valid;
    end
    check("stall_valid_seen", 64'(hit), 64'd1);
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      check("stall_valid_held", 64'(out_valid), 64'd1);
    end
    ready_mode = 0;
    wait_done(cyc);
    check("stall_done_pulses", 64'(done_cnt - d0), 64'd1);

    // Register write at the capture edge of reg 7 must not be seen.
    mem[7] <= 32'h1111_1111;
    @(posedge clk);
    #1;
    fork
      run_dump(5, 9, 1'b1);
      begin
        hit = 1'b0;
        for (int t = 0; t < 100 && !hit; t++) begin
          @(negedge clk);
          hit = (rf_addr == 5'd7);
        end
        @(posedge clk);
        mem[7] <= 32'hDEAD_BEEF;
      end
    join
    run_dump(7, 7, 1'b1);

    // Asynchronous reset while the word at address 3 is on the output.
    d0 = done_cnt;
    start_dump(1, 9);
    hit = 1'b0;
    for (int t = 0; t < 100 && !hit; t++) begin
      @(negedge clk);
      hit = out_valid && (out_addr == 5'd3);
    end
    check("reached_word3", 64'(hit), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_rf_addr", 64'(rf_addr), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_no_done", 64'(done_cnt - d0), 64'd0);
    run_dump(1, 4, 1'b1);

    // start while busy with another range is ignored.
    fork
      run_dump(10, 14, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #2;
        first_addr = 5'd20;
        last_addr  = 5'd25;
        start      = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
      end
    join

    // Randomized contents, ranges and back-pressure.
    ready_mode = 1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 32; i++) mem[i] <= $urandom;
      @(posedge clk);
      #1;
      run_dump(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'b0);
    end
    ready_mode = 0;

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
